// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, key event layout and frame FSM encoding for the PS/2 keyboard receiver.
package ps2_pkg;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
    localparam logic [7:0] PS2_OVR0       = 8'h00;
    localparam logic [7:0] PS2_OVR1       = 8'hFF;
    localparam int         PS2_EV_W       = 10;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_ev_t;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_st_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the PS/2 pins and assembles parity/stop checked bytes with a frame timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic [7:0] data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [1:0]    ck_sync_q, dt_sync_q;
    logic          ck_s, dt_s, filt_q, filt_d, strobe, tmo_hit;
    logic [7:0]    fcnt_q, fcnt_d, sh_q, sh_d;
    logic [2:0]    idx_q, idx_d;
    logic          par_q, par_d, bv_q, bv_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    frame_st_t     st_q, st_d;

    assign ck_s         = ck_sync_q[1];
    assign dt_s         = dt_sync_q[1];
    assign data_o       = sh_q;
    assign byte_valid_o = bv_q;
    assign frame_err_o  = err_q | tmo_hit;

    // The filtered level only follows the pin after it has held FILTER_LEN cycles.
    always_comb begin
        fcnt_d = (ck_s == filt_q) ? '0 : fcnt_q + 8'd1;
        filt_d = filt_q;
        if (fcnt_d == 8'(FILTER_LEN)) begin
            filt_d = ~filt_q;
            fcnt_d = '0;
        end
        strobe = filt_q & ~filt_d;
    end

    always_comb begin
        st_d    = st_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        bv_d    = 1'b0;
        err_d   = 1'b0;
        tmo_hit = (st_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYC));
        tmo_d   = (st_q == ST_IDLE || strobe) ? '0 : tmo_q + TW'(1);
        if (tmo_hit) begin
            st_d  = ST_IDLE;
            tmo_d = '0;
        end else if (strobe) begin
            case (st_q)
                ST_IDLE: begin
                    st_d  = dt_s ? ST_IDLE : ST_DATA;
                    idx_d = '0;
                end
                ST_DATA: begin
                    sh_d  = {dt_s, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    st_d  = (idx_q == 3'd7) ? ST_PARITY : ST_DATA;
                end
                ST_PARITY: begin
                    par_d = dt_s;
                    st_d  = ST_STOP;
                end
                default: begin
                    bv_d  = dt_s & (^{sh_q, par_q});
                    err_d = ~(dt_s & (^{sh_q, par_q}));
                    st_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_sync_q <= 2'b11;
            dt_sync_q <= 2'b11;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            st_q      <= ST_IDLE;
            sh_q      <= '0;
            idx_q     <= '0;
            par_q     <= 1'b0;
            bv_q      <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ps2clk_i};
            dt_sync_q <= {dt_sync_q[0], ps2data_i};
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            st_q      <= st_d;
            sh_q      <= sh_d;
            idx_q     <= idx_d;
            par_q     <= par_d;
            bv_q      <= bv_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end
endmodule

// File: rtl/ps2_kbd_event_rx.sv
// ps2_kbd_event_rx: PS/2 keyboard front end folding E0/F0 prefixes into key events queued in a show-ahead FIFO.
module ps2_kbd_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2clk,
    input  logic                          ps2data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_release,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          err_ind,
    input  logic                          clr_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    rx_byte;
    logic          rx_bv, rx_err, ovr, pop, full, wr, drop;
    logic          ext_q, ext_d, rel_q, rel_d, push_q, push_d, ovf_q, ovf_d;
    ps2_ev_t       ev_q, ev_d, head;
    ps2_ev_t       mem [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame (
        .clk         (clk),
        .rst         (rst),
        .ps2clk_i    (ps2clk),
        .ps2data_i   (ps2data),
        .data_o      (rx_byte),
        .byte_valid_o(rx_bv),
        .frame_err_o (rx_err)
    );

    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        ev_d   = ev_q;
        push_d = 1'b0;
        ovr    = 1'b0;
        if (rx_bv) begin
            if (rx_byte == PS2_PREFIX_EXT) ext_d = 1'b1;
            else if (rx_byte == PS2_PREFIX_REL) rel_d = 1'b1;
            else begin
                ovr    = (rx_byte == PS2_OVR0) || (rx_byte == PS2_OVR1);
                push_d = ~ovr;
                ev_d   = {ext_q, rel_q, rx_byte};
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end
        end
    end

    // A push into a full FIFO is only lost when no pop frees a slot in the same cycle.
    always_comb begin
        pop   = ev_valid & ev_ready;
        full  = cnt_q == CW'(FIFO_DEPTH);
        wr    = push_q & (~full | pop);
        drop  = push_q & full & ~pop;
        wp_d  = wr ? wp_q + AW'(1) : wp_q;
        rp_d  = pop ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
        ovf_d = drop ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= ev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            push_q <= 1'b0;
            ev_q   <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            push_q <= push_d;
            ev_q   <= ev_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign head       = mem[rp_q];
    assign ev_valid   = cnt_q != '0;
    assign ev_code    = ev_valid ? head.code : 8'h00;
    assign ev_ext     = ev_valid & head.ext;
    assign ev_release = ev_valid & head.rel;
    assign ev_count   = cnt_q;
    assign overflow   = ovf_q;
    assign err_ind    = rx_err | (rx_bv & ovr);
endmodule
